// File: rtl/time_pkg.sv
// Shared constants for the BCD time chain and its display paths.
// Segment patterns are active-high, bit order {g,f,e,d,c,b,a}.
package time_pkg;

  localparam int FLD_SS = 0;
  localparam int FLD_MM = 1;
  localparam int FLD_HH = 2;

  localparam int NDIG = 6;

  localparam logic [6:0] SEG_0    = 7'b0111111;
  localparam logic [6:0] SEG_1    = 7'b0000110;
  localparam logic [6:0] SEG_2    = 7'b1011011;
  localparam logic [6:0] SEG_3    = 7'b1001111;
  localparam logic [6:0] SEG_4    = 7'b1100110;
  localparam logic [6:0] SEG_5    = 7'b1101101;
  localparam logic [6:0] SEG_6    = 7'b1111101;
  localparam logic [6:0] SEG_7    = 7'b0000111;
  localparam logic [6:0] SEG_8    = 7'b1111111;
  localparam logic [6:0] SEG_9    = 7'b1101111;
  localparam logic [6:0] SEG_DASH = 7'b1000000;
  localparam logic [6:0] SEG_OFF  = 7'b0000000;

  typedef enum logic {
    PH_VISIBLE = 1'b0,
    PH_BLANKED = 1'b1
  } blink_phase_e;

  // Digits are paired per field: 0/1 = ss, 2/3 = mm, 4/5 = hh.
  function automatic logic [1:0] field_of(input logic [2:0] digit);
    return digit[2:1];
  endfunction

endpackage

// File: rtl/seg7_scan_display_if.sv
// Display-side bundle: time/control inputs from the clock logic and the board pins.
interface seg7_scan_display_if;

  logic        en;
  logic [23:0] time_bcd;
  logic [2:0]  blink_mask;
  logic [5:0]  dp_mask;
  logic [6:0]  seg;
  logic        dp;
  logic [5:0]  dig_sel;

  modport master (
    output en, time_bcd, blink_mask, dp_mask,
    input  seg, dp, dig_sel
  );

  modport slave (
    input  en, time_bcd, blink_mask, dp_mask,
    output seg, dp, dig_sel
  );

endinterface

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit decoder; any non-decimal nibble shows a dash.
module bcd_to_seg7
  import time_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (nib)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_display.sv
// Six-digit multiplexed 7-segment driver for hh:mm:ss with frame-coherent
// snapshot, per-field blinking, hours leading-zero blanking and pin polarity.
module seg7_scan_display
  import time_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int BLINK_FRAMES   = 64,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1,
  parameter int LZB            = 1
) (
  input  logic               clk,
  input  logic               reset,
  seg7_scan_display_if.slave bus
);

  localparam int DIV_W  = $clog2(SCAN_DIV);
  localparam int BCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [2:0]        LAST_DIG  = 3'(NDIG - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BLINK_FRAMES - 1);

  localparam logic [6:0]      SEG_INV = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic            DP_INV  = (SEG_ACTIVE_LOW != 0);
  localparam logic [NDIG-1:0] DIG_INV = (DIG_ACTIVE_LOW != 0) ? 6'h3F : 6'h00;

  logic [DIV_W-1:0]  div;
  logic [2:0]        idx;
  logic [BCNT_W-1:0] bcnt;
  blink_phase_e      phase;
  logic [23:0]       snap;

  logic              tick;
  logic              frame_wrap;
  logic              blink_wrap;
  logic [2:0]        idx_nxt;
  logic [23:0]       snap_nxt;
  blink_phase_e      phase_nxt;

  logic [3:0]        nib;
  logic [6:0]        pattern;
  logic              blank;

  logic [6:0]        seg_q;
  logic              dp_q;
  logic [NDIG-1:0]   dig_q;

  assign tick       = bus.en && (div == DIV_LAST);
  assign frame_wrap = tick && (idx == LAST_DIG);
  assign blink_wrap = frame_wrap && (bcnt == BCNT_LAST);

  // The output register is fed from next-state values so the pins follow
  // idx with no extra lag and a new snapshot/phase lands on idx 0 directly.
  always_comb begin
    idx_nxt   = idx;
    snap_nxt  = snap;
    phase_nxt = phase;
    if (tick) begin
      idx_nxt = (idx == LAST_DIG) ? 3'd0 : idx + 3'd1;
    end
    if (frame_wrap) begin
      snap_nxt = bus.time_bcd;
    end
    if (blink_wrap) begin
      phase_nxt = (phase == PH_VISIBLE) ? PH_BLANKED : PH_VISIBLE;
    end
  end

  always_comb begin
    nib = snap_nxt[3:0];
    case (idx_nxt)
      3'd1: nib = snap_nxt[7:4];
      3'd2: nib = snap_nxt[11:8];
      3'd3: nib = snap_nxt[15:12];
      3'd4: nib = snap_nxt[19:16];
      3'd5: nib = snap_nxt[23:20];
      default: nib = snap_nxt[3:0];
    endcase
  end

  bcd_to_seg7 u_dec (
    .nib (nib),
    .seg (pattern)
  );

  assign blank = ((phase_nxt == PH_BLANKED) && bus.blink_mask[field_of(idx_nxt)])
              || ((LZB != 0) && (idx_nxt == LAST_DIG) && (nib == 4'd0));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div   <= '0;
      idx   <= 3'd0;
      bcnt  <= '0;
      phase <= PH_VISIBLE;
      snap  <= 24'h0;
    end else if (bus.en) begin
      div   <= tick ? '0 : div + DIV_W'(1);
      idx   <= idx_nxt;
      snap  <= snap_nxt;
      phase <= phase_nxt;
      if (frame_wrap) begin
        bcnt <= blink_wrap ? '0 : bcnt + BCNT_W'(1);
      end
    end
  end

  // Pin levels are stored directly; a blanked digit keeps its dig_sel so
  // every slot has the same on-time and brightness stays even.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_q <= SEG_OFF ^ SEG_INV;
      dp_q  <= DP_INV;
      dig_q <= DIG_INV;
    end else if (bus.en) begin
      seg_q <= (blank ? SEG_OFF : pattern) ^ SEG_INV;
      dp_q  <= (!blank && bus.dp_mask[idx_nxt]) ^ DP_INV;
      dig_q <= (NDIG'(1) << idx_nxt) ^ DIG_INV;
    end else begin
      seg_q <= SEG_OFF ^ SEG_INV;
      dp_q  <= DP_INV;
      dig_q <= DIG_INV;
    end
  end

  assign bus.seg     = seg_q;
  assign bus.dp      = dp_q;
  assign bus.dig_sel = dig_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Scoreboard bench for seg7_scan_display: a cycle-count reference model
// predicts every pin value, a monitor compares one cycle at a time.
module tb_seg7_scan_display;

  localparam int SCAN_DIV     = 4;
  localparam int BLINK_FRAMES = 2;
  localparam int FRAME        = 6 * SCAN_DIV;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [5:0] dig;
  } pins_t;

  localparam pins_t IDLE = '{seg: 7'h7F, dp: 1'b1, dig: 6'h3F};

  logic clk = 1'b0;
  logic reset = 1'b0;

  int total = 0;
  int bad = 0;

  pins_t expq[$];
  int n = 0;
  logic [23:0] snap_m = 24'h0;

  logic [6:0] seg_tab [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40
  };

  seg7_scan_display_if bus ();

  seg7_scan_display #(
    .SCAN_DIV       (SCAN_DIV),
    .BLINK_FRAMES   (BLINK_FRAMES),
    .SEG_ACTIVE_LOW (1),
    .DIG_ACTIVE_LOW (1),
    .LZB            (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [23:0] act, input logic [23:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic applyStimulus(input logic e, input logic [23:0] t, input logic [2:0] b,
                               input logic [5:0] d, input int cycles);
    bus.en         = e;
    bus.time_bcd   = t;
    bus.blink_mask = b;
    bus.dp_mask    = d;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic pulseReset();
    reset = 1'b0;
    #1;
    checkOutput("async_rst_seg", 24'(bus.seg), 24'h7F);
    checkOutput("async_rst_dp", 24'(bus.dp), 24'h1);
    checkOutput("async_rst_dig", 24'(bus.dig_sel), 24'h3F);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Reference model: state is derived from the number of enabled clocks
  // since reset, so slot, frame and blink phase are plain divisions.
  always @(posedge clk) begin : model
    pins_t e;
    int d;
    int ph;
    logic [2:0] dl;
    logic [3:0] nib;
    logic blank;
    e = IDLE;
    if (!reset) begin
      n = 0;
      snap_m = 24'h0;
    end else if (bus.en) begin
      n = n + 1;
      if (n % FRAME == 0) snap_m = bus.time_bcd;
      d = (n / SCAN_DIV) % 6;
      dl = 3'(d);
      ph = ((n / FRAME) / BLINK_FRAMES) % 2;
      nib = 4'(snap_m >> (4 * d));
      blank = (ph == 1 && bus.blink_mask[dl[2:1]]) || (d == 5 && nib == 4'd0);
      e.seg = blank ? 7'h7F : ~seg_tab[nib];
      e.dp  = blank ? 1'b1 : ~bus.dp_mask[dl];
      e.dig = ~(6'b000001 << d);
    end
    expq.push_back(e);
  end

  always @(posedge clk) begin : monitor
    pins_t e;
    #1;
    if (expq.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard_empty actual=0 expected=1 at %0t", $time);
    end else begin
      e = expq.pop_front();
      checkOutput("seg", 24'(bus.seg), 24'(e.seg));
      checkOutput("dp", 24'(bus.dp), 24'(e.dp));
      checkOutput("dig_sel", 24'(bus.dig_sel), 24'(e.dig));
    end
  end

  initial begin
    bit found;
    bus.en         = 1'b0;
    bus.time_bcd   = 24'h0;
    bus.blink_mask = 3'b000;
    bus.dp_mask    = 6'h00;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    $display("[TB] reset released");

    applyStimulus(1'b1, 24'h123456, 3'b000, 6'h00, 2 * FRAME);
    applyStimulus(1'b1, 24'h123456, 3'b000, 6'h00, 2 * SCAN_DIV + 1);
    applyStimulus(1'b1, 24'h235959, 3'b000, 6'h00, 2 * FRAME);
    applyStimulus(1'b1, 24'h101010, 3'b010, 6'h00, 5 * FRAME);
    applyStimulus(1'b1, 24'h0A0F00, 3'b000, 6'h00, 2 * FRAME);
    applyStimulus(1'b1, 24'h0A0F00, 3'b000, 6'b000100, 2 * SCAN_DIV + 2);
    applyStimulus(1'b0, 24'h0A0F00, 3'b000, 6'b000100, 10);
    applyStimulus(1'b1, 24'h0A0F00, 3'b000, 6'b000100, 2 * FRAME);

    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (bus.dig_sel == 6'b110111) found = 1'b1;
      else @(negedge clk);
    end
    if (!found) begin
      total++;
      bad++;
      $display("[TB] FAIL wait_idx3 actual=timeout expected=dig_sel 110111");
    end
    pulseReset();
    applyStimulus(1'b1, 24'h123456, 3'b000, 6'h00, 2 * FRAME);

    $display("[TB] random phase");
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 19) == 0) pulseReset();
      applyStimulus(($urandom_range(0, 7) != 0), 24'($urandom), 3'($urandom),
                    6'($urandom), int'($urandom_range(1, 30)));
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
